// File: rtl/fir_coef_pkg.sv
// Shared types and defaults for the FIR coefficient loader.
package fir_coef_pkg;

  localparam int unsigned NUM_COEF_DEF = 50;
  localparam logic [7:0]  HEADER_DEF   = 8'hA5;

  typedef logic signed [15:0] coef_t;

  typedef enum logic [2:0] {
    IDLE,
    RECV,
    CHECK,
    SEND,
    WAIT_ACK
  } state_t;

endpackage

// File: rtl/fir_coef_frame_rx.sv
// Frame byte assembly: coefficient write port, running XOR checksum and inter-byte gap timer.
module fir_coef_frame_rx
  import fir_coef_pkg::*;
#(
  parameter int unsigned NUM_COEF    = NUM_COEF_DEF,
  parameter int unsigned GAP_TIMEOUT = 500000
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       start,
  input  logic       in_recv,
  input  logic       in_check,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  output logic       wr_en,
  output logic [5:0] wr_idx,
  output logic       wr_hi,
  output logic [7:0] wr_byte,
  output logic       data_done,
  output logic       frame_ok,
  output logic       frame_err
);

  localparam int unsigned GW        = $clog2(GAP_TIMEOUT + 1);
  localparam logic [6:0]  LAST_BYTE = 7'(2 * NUM_COEF - 1);
  localparam logic [GW-1:0] GAP_LAST = GW'(GAP_TIMEOUT - 1);

  logic [6:0]    byte_cnt;
  logic [7:0]    run_xor;
  logic [GW-1:0] gap_cnt;
  logic          active;
  logic          gap_expired;

  // Decode the current byte into a write-port access and frame completion/error strobes.
  always_comb begin
    active      = in_recv | in_check;
    wr_en       = in_recv & rx_valid;
    wr_idx      = byte_cnt[6:1];
    wr_hi       = ~byte_cnt[0];
    wr_byte     = rx_data;
    data_done   = wr_en && (byte_cnt == LAST_BYTE);
    gap_expired = active && !rx_valid && (gap_cnt == GAP_LAST);
    frame_ok    = in_check && rx_valid && (rx_data == run_xor);
    frame_err   = (in_check && rx_valid && (rx_data != run_xor)) || gap_expired;
  end

  // Byte counter, running checksum and idle-clock counter, all cleared at frame start.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      byte_cnt <= '0;
      run_xor  <= '0;
      gap_cnt  <= '0;
    end else if (start) begin
      byte_cnt <= '0;
      run_xor  <= '0;
      gap_cnt  <= '0;
    end else begin
      if (wr_en) begin
        byte_cnt <= byte_cnt + 7'd1;
        run_xor  <= run_xor ^ rx_data;
      end
      if (active) begin
        gap_cnt <= rx_valid ? '0 : gap_cnt + GW'(1);
      end
    end
  end

endmodule

// File: rtl/fir_coef_sender.sv
// Loads a coefficient frame from UART bytes and streams it to the FIR coefficient port.
module fir_coef_sender
  import fir_coef_pkg::*;
#(
  parameter int unsigned NUM_COEF    = NUM_COEF_DEF,
  parameter int unsigned COEF_HOLD   = 2,
  parameter int unsigned GAP_TIMEOUT = 500000,
  parameter int unsigned ACK_TIMEOUT = 1024,
  parameter logic [7:0]  HEADER      = HEADER_DEF
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic [7:0]         rx_data,
  input  logic               rx_valid,
  input  logic               resend,
  input  logic               fir_data_rec_valid,
  output logic               out_ing_valid,
  output logic [5:0]         out_cnt,
  output logic signed [15:0] fir_data,
  output logic               busy,
  output logic               coef_ready,
  output logic               load_ok,
  output logic               load_err
);

  localparam int unsigned HW = $clog2(COEF_HOLD + 1);
  localparam int unsigned AW = $clog2(ACK_TIMEOUT + 1);

  state_t        state, state_next;
  coef_t         coef_mem [NUM_COEF];
  logic [HW-1:0] hold_cnt;
  logic [AW-1:0] ack_cnt;
  logic          start, send_enter;
  logic          in_recv, in_check;
  logic          hold_last, idx_last, ack_expired;
  logic          wr_en, wr_hi, data_done, frame_ok, frame_err;
  logic [5:0]    wr_idx;
  logic [7:0]    wr_byte;

  fir_coef_frame_rx #(
    .NUM_COEF    (NUM_COEF),
    .GAP_TIMEOUT (GAP_TIMEOUT)
  ) u_frame_rx (
    .clk       (clk),
    .rstn      (rstn),
    .start     (start),
    .in_recv   (in_recv),
    .in_check  (in_check),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .wr_en     (wr_en),
    .wr_idx    (wr_idx),
    .wr_hi     (wr_hi),
    .wr_byte   (wr_byte),
    .data_done (data_done),
    .frame_ok  (frame_ok),
    .frame_err (frame_err)
  );

  // Next-state decode; a HEADER byte in IDLE takes priority over resend.
  always_comb begin
    state_next  = state;
    start       = 1'b0;
    send_enter  = 1'b0;
    in_recv     = (state == RECV);
    in_check    = (state == CHECK);
    busy        = (state != IDLE);
    hold_last   = (hold_cnt == HW'(COEF_HOLD - 1));
    idx_last    = (out_cnt == 6'(NUM_COEF - 1));
    ack_expired = !fir_data_rec_valid && (ack_cnt == AW'(ACK_TIMEOUT - 1));
    case (state)
      IDLE: begin
        if (rx_valid && (rx_data == HEADER)) begin
          state_next = RECV;
          start      = 1'b1;
        end else if (resend && coef_ready) begin
          state_next = SEND;
          send_enter = 1'b1;
        end
      end
      RECV: begin
        if (frame_err)      state_next = IDLE;
        else if (data_done) state_next = CHECK;
      end
      CHECK: begin
        if (frame_ok) begin
          state_next = SEND;
          send_enter = 1'b1;
        end else if (frame_err) begin
          state_next = IDLE;
        end
      end
      SEND: begin
        if (hold_last && idx_last) state_next = WAIT_ACK;
      end
      WAIT_ACK: begin
        if (fir_data_rec_valid || ack_expired) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= IDLE;
    else       state <= state_next;
  end

  // Coefficient storage, written one byte at a time by the frame receiver.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int unsigned i = 0; i < NUM_COEF; i++) coef_mem[i] <= '0;
    end else if (wr_en) begin
      if (wr_hi) coef_mem[wr_idx][15:8] <= wr_byte;
      else       coef_mem[wr_idx][7:0]  <= wr_byte;
    end
  end

  // Streaming outputs: fir_data is loaded together with out_cnt so the pair is
  // coherent on every hold clock; the final hold clock clears all three.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      out_ing_valid <= 1'b0;
      out_cnt       <= '0;
      fir_data      <= '0;
      hold_cnt      <= '0;
    end else if (send_enter) begin
      out_ing_valid <= 1'b1;
      out_cnt       <= '0;
      fir_data      <= coef_mem[0];
      hold_cnt      <= '0;
    end else if (state == SEND) begin
      if (hold_last) begin
        hold_cnt <= '0;
        if (idx_last) begin
          out_ing_valid <= 1'b0;
          out_cnt       <= '0;
          fir_data      <= '0;
        end else begin
          out_cnt  <= out_cnt + 6'd1;
          fir_data <= coef_mem[out_cnt + 6'd1];
        end
      end else begin
        hold_cnt <= hold_cnt + HW'(1);
      end
    end
  end

  // Acknowledge wait timer, running only in WAIT_ACK.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)                 ack_cnt <= '0;
    else if (state == WAIT_ACK) ack_cnt <= ack_cnt + AW'(1);
    else                       ack_cnt <= '0;
  end

  // Status flags and one-clock result pulses.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      load_ok    <= 1'b0;
      load_err   <= 1'b0;
      coef_ready <= 1'b0;
    end else begin
      load_ok  <= (state == WAIT_ACK) && fir_data_rec_valid;
      load_err <= frame_err || ((state == WAIT_ACK) && ack_expired);
      if (start)         coef_ready <= 1'b0;
      else if (frame_ok) coef_ready <= 1'b1;
    end
  end

endmodule

// File: tb/tb_fir_coef_sender.sv
// Self-checking bench for fir_coef_sender with a frame/stream reference model.
module tb_fir_coef_sender;

  localparam int N    = 50;
  localparam int HOLD = 2;
  localparam int GAP  = 300;
  localparam int ACK  = 64;
  localparam logic [7:0] HDR = 8'hA5;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  logic [7:0] rx_data = '0;
  logic rx_valid = 1'b0;
  logic resend = 1'b0;
  logic fir_ack = 1'b0;
  logic out_ing_valid;
  logic [5:0] out_cnt;
  logic signed [15:0] fir_data;
  logic busy, coef_ready, load_ok, load_err;

  fir_coef_sender #(
    .NUM_COEF    (N),
    .COEF_HOLD   (HOLD),
    .GAP_TIMEOUT (GAP),
    .ACK_TIMEOUT (ACK),
    .HEADER      (HDR)
  ) dut (
    .clk                (clk),
    .rstn               (rstn),
    .rx_data            (rx_data),
    .rx_valid           (rx_valid),
    .resend             (resend),
    .fir_data_rec_valid (fir_ack),
    .out_ing_valid      (out_ing_valid),
    .out_cnt            (out_cnt),
    .fir_data           (fir_data),
    .busy               (busy),
    .coef_ready         (coef_ready),
    .load_ok            (load_ok),
    .load_err           (load_err)
  );

  always #10 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Observed activity, recorded on the falling edge.
  logic [21:0] slog[$];
  int rise_cnt = 0, ok_cnt = 0, err_cnt = 0, err_cyc = 0, fall_cyc = 0;
  int busy_bad = 0, range_bad = 0;
  logic prev_v = 1'b0;

  always @(negedge clk) begin
    if (rstn) begin
      if (out_ing_valid) begin
        slog.push_back({out_cnt, fir_data});
        if (!prev_v) rise_cnt++;
        if (!busy) busy_bad++;
      end
      if (prev_v && !out_ing_valid) fall_cyc = cyc;
      if (out_cnt > 6'(N - 1)) range_bad++;
      if (load_ok) ok_cnt++;
      if (load_err) begin
        err_cnt++;
        err_cyc = cyc;
      end
      prev_v = out_ing_valid;
    end
  end

  int cmp = 0, mis = 0;
  int last_rx_cyc = 0;
  logic signed [15:0] exp_coef [N];

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Expected stream: index k presented HOLD times in a row with its coefficient.
  function automatic int stream_diff(input int base);
    int bad = 0;
    logic [21:0] e;
    for (int j = 0; j < N * HOLD; j++) begin
      e = {6'(j / HOLD), exp_coef[j / HOLD]};
      if (base + j >= slog.size()) bad++;
      else if (slog[base + j] !== e) bad++;
    end
    return bad;
  endfunction

  task automatic send_byte(input logic [7:0] b, input bit with_resend);
    rx_data  = b;
    rx_valid = 1'b1;
    resend   = with_resend;
    @(posedge clk); #1;
    last_rx_cyc = cyc;
    rx_valid = 1'b0;
    resend   = 1'b0;
    repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
  endtask

  task automatic send_frame(input logic [7:0] ck_flip, input int first, input int count);
    logic [7:0] q[$];
    logic [7:0] ck;
    logic [15:0] c;
    ck = '0;
    q.push_back(HDR);
    for (int i = 0; i < N; i++) begin
      c = exp_coef[i];
      q.push_back(c[15:8]);
      q.push_back(c[7:0]);
      ck = ck ^ c[15:8] ^ c[7:0];
    end
    q.push_back(ck ^ ck_flip);
    for (int i = first; i < q.size() && i < first + count; i++) send_byte(q[i], 1'b0);
  endtask

  task automatic wait_done(input int limit, input bit auto_ack, input int b_ok, input int b_err,
                           output bit to);
    to = 1'b1;
    for (int i = 0; i < limit; i++) begin
      @(negedge clk); #1;
      if (auto_ack && out_ing_valid && out_cnt == 6'(N - 1)) fir_ack = 1'b1;
      if (ok_cnt != b_ok || err_cnt != b_err) begin
        to = 1'b0;
        break;
      end
    end
  endtask

  task automatic randomize_coefs();
    for (int i = 0; i < N; i++) exp_coef[i] = 16'($urandom);
  endtask

  task automatic test_reset();
    logic [27:0] outs;
    rstn = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    outs = {out_ing_valid, out_cnt, fir_data, busy, coef_ready, load_ok, load_err};
    cmp++;
    if (outs !== '0) begin mis++; $display("FAIL reset_hold: outputs=%h required 0", outs); end
    rstn = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    outs = {out_ing_valid, out_cnt, fir_data, busy, coef_ready, load_ok, load_err};
    cmp++;
    if (outs !== '0) begin mis++; $display("FAIL reset_release: outputs=%h required 0", outs); end
  endtask

  task automatic test_valid_frame();
    int b_ok = ok_cnt, b_err = err_cnt, b_rise = rise_cnt, b_s = slog.size(), d;
    bit to;
    for (int i = 0; i < N; i++) exp_coef[i] = 16'(100 * i - 2500);
    fir_ack = 1'b0;
    send_frame(8'h00, 0, 1000);
    wait_done(2000, 1'b1, b_ok, b_err, to);
    repeat (3) @(negedge clk);
    cmp++; if (to) begin mis++; $display("FAIL valid_timeout: no load result, required load_ok"); end
    d = slog.size() - b_s;
    cmp++; if (d !== N * HOLD) begin mis++; $display("FAIL valid_len: got %0d required %0d", d, N * HOLD); end
    d = stream_diff(b_s);
    cmp++; if (d !== 0) begin mis++; $display("FAIL valid_stream: bad samples %0d required 0", d); end
    cmp++; if (rise_cnt - b_rise !== 1) begin mis++; $display("FAIL valid_rises: got %0d required 1", rise_cnt - b_rise); end
    cmp++; if (ok_cnt - b_ok !== 1) begin mis++; $display("FAIL valid_ok: got %0d required 1", ok_cnt - b_ok); end
    cmp++; if (err_cnt - b_err !== 0) begin mis++; $display("FAIL valid_err: got %0d required 0", err_cnt - b_err); end
    cmp++; if (coef_ready !== 1'b1) begin mis++; $display("FAIL valid_ready: got %b required 1", coef_ready); end
    cmp++; if (busy !== 1'b0) begin mis++; $display("FAIL valid_busy: got %b required 0", busy); end
  endtask

  task automatic test_bad_checksum();
    int b_ok = ok_cnt, b_err = err_cnt, b_rise = rise_cnt;
    bit to;
    for (int i = 0; i < N; i++) exp_coef[i] = 16'(100 * i - 2500);
    fir_ack = 1'b0;
    send_frame(8'h01, 0, 1000);
    wait_done(50, 1'b0, b_ok, b_err, to);
    repeat (5) @(negedge clk);
    cmp++; if (to) begin mis++; $display("FAIL badck_timeout: no load result, required load_err"); end
    cmp++; if (err_cnt - b_err !== 1) begin mis++; $display("FAIL badck_err: got %0d required 1", err_cnt - b_err); end
    cmp++; if (rise_cnt - b_rise !== 0) begin mis++; $display("FAIL badck_send: streams %0d required 0", rise_cnt - b_rise); end
    cmp++; if (ok_cnt - b_ok !== 0) begin mis++; $display("FAIL badck_ok: got %0d required 0", ok_cnt - b_ok); end
    cmp++; if (coef_ready !== 1'b0) begin mis++; $display("FAIL badck_ready: got %b required 0", coef_ready); end
    cmp++; if (busy !== 1'b0) begin mis++; $display("FAIL badck_busy: got %b required 0", busy); end
  endtask

  task automatic test_gap_timeout();
    int b_ok = ok_cnt, b_err = err_cnt, b_rise = rise_cnt, b_s, d;
    bit to;
    randomize_coefs();
    fir_ack = 1'b0;
    send_frame(8'h00, 0, 37);
    wait_done(GAP + 50, 1'b0, b_ok, b_err, to);
    repeat (2) @(negedge clk);
    cmp++; if (to) begin mis++; $display("FAIL gap_timeout: no load_err within bound"); end
    cmp++; if (err_cnt - b_err !== 1) begin mis++; $display("FAIL gap_err: got %0d required 1", err_cnt - b_err); end
    d = err_cyc - last_rx_cyc;
    cmp++; if (d !== GAP) begin mis++; $display("FAIL gap_latency: got %0d required %0d", d, GAP); end
    cmp++; if (busy !== 1'b0) begin mis++; $display("FAIL gap_busy: got %b required 0", busy); end
    cmp++; if (coef_ready !== 1'b0) begin mis++; $display("FAIL gap_ready: got %b required 0", coef_ready); end
    cmp++; if (rise_cnt - b_rise !== 0) begin mis++; $display("FAIL gap_send: streams %0d required 0", rise_cnt - b_rise); end
    // A clean frame afterwards must load normally.
    randomize_coefs();
    b_ok = ok_cnt; b_err = err_cnt; b_s = slog.size();
    send_frame(8'h00, 0, 1000);
    wait_done(2000, 1'b1, b_ok, b_err, to);
    cmp++; if (to || ok_cnt - b_ok !== 1) begin mis++; $display("FAIL gap_reload_ok: got %0d required 1", ok_cnt - b_ok); end
    d = stream_diff(b_s);
    cmp++; if (d !== 0) begin mis++; $display("FAIL gap_reload_stream: bad samples %0d required 0", d); end
  endtask

  task automatic test_ack_timeout_resend();
    int b_ok = ok_cnt, b_err = err_cnt, b_s = slog.size(), d;
    bit to;
    randomize_coefs();
    fir_ack = 1'b0;
    send_frame(8'h00, 0, 1000);
    wait_done(2000, 1'b0, b_ok, b_err, to);
    repeat (2) @(negedge clk);
    cmp++; if (to) begin mis++; $display("FAIL ack_timeout_wait: no load result within bound"); end
    d = stream_diff(b_s);
    cmp++; if (d !== 0) begin mis++; $display("FAIL ack_stream: bad samples %0d required 0", d); end
    cmp++; if (err_cnt - b_err !== 1) begin mis++; $display("FAIL ack_err: got %0d required 1", err_cnt - b_err); end
    d = err_cyc - fall_cyc;
    cmp++; if (d !== ACK) begin mis++; $display("FAIL ack_latency: got %0d required %0d", d, ACK); end
    cmp++; if (coef_ready !== 1'b1) begin mis++; $display("FAIL ack_ready: got %b required 1", coef_ready); end
    cmp++; if (ok_cnt - b_ok !== 0) begin mis++; $display("FAIL ack_ok: got %0d required 0", ok_cnt - b_ok); end
    // Resend with the acknowledge already high.
    b_ok = ok_cnt; b_err = err_cnt; b_s = slog.size();
    fir_ack = 1'b1;
    resend = 1'b1;
    @(posedge clk); #1;
    resend = 1'b0;
    wait_done(500, 1'b1, b_ok, b_err, to);
    repeat (2) @(negedge clk);
    d = slog.size() - b_s;
    cmp++; if (d !== N * HOLD) begin mis++; $display("FAIL resend_len: got %0d required %0d", d, N * HOLD); end
    d = stream_diff(b_s);
    cmp++; if (d !== 0) begin mis++; $display("FAIL resend_stream: bad samples %0d required 0", d); end
    cmp++; if (to || ok_cnt - b_ok !== 1) begin mis++; $display("FAIL resend_ok: got %0d required 1", ok_cnt - b_ok); end
  endtask

  task automatic test_send_ignore();
    int b_ok = ok_cnt, b_err = err_cnt, b_rise = rise_cnt, b_s = slog.size(), d;
    bit to;
    randomize_coefs();
    fir_ack = 1'b0;
    // HEADER and resend in the same IDLE clock: the header wins.
    send_byte(HDR, 1'b1);
    cmp++; if (coef_ready !== 1'b0) begin mis++; $display("FAIL collide_ready: got %b required 0", coef_ready); end
    cmp++; if (out_ing_valid !== 1'b0) begin mis++; $display("FAIL collide_send: got %b required 0", out_ing_valid); end
    send_frame(8'h00, 1, 1000);
    to = 1'b1;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk); #1;
      if (out_ing_valid && out_cnt == 6'(N - 1)) fir_ack = 1'b1;
      if (out_ing_valid && out_cnt < 6'd40) begin
        rx_valid = 1'b1;
        rx_data  = (i % 2 == 0) ? HDR : 8'($urandom);
        resend   = 1'b1;
      end else begin
        rx_valid = 1'b0;
        resend   = 1'b0;
      end
      if (ok_cnt != b_ok || err_cnt != b_err) begin to = 1'b0; break; end
    end
    rx_valid = 1'b0;
    resend   = 1'b0;
    repeat (10) @(negedge clk);
    cmp++; if (to || ok_cnt - b_ok !== 1) begin mis++; $display("FAIL ignore_ok: got %0d required 1", ok_cnt - b_ok); end
    d = stream_diff(b_s);
    cmp++; if (d !== 0) begin mis++; $display("FAIL ignore_stream: bad samples %0d required 0", d); end
    cmp++; if (rise_cnt - b_rise !== 1) begin mis++; $display("FAIL ignore_rises: got %0d required 1", rise_cnt - b_rise); end
    cmp++; if (busy_bad !== 0) begin mis++; $display("FAIL ignore_busy: low-busy stream clocks %0d required 0", busy_bad); end
    cmp++; if (coef_ready !== 1'b1) begin mis++; $display("FAIL ignore_ready: got %b required 1", coef_ready); end
    cmp++; if (busy !== 1'b0) begin mis++; $display("FAIL ignore_idle: got %b required 0", busy); end
    cmp++; if (range_bad !== 0) begin mis++; $display("FAIL cnt_range: out-of-range clocks %0d required 0", range_bad); end
  endtask

  task automatic test_reset_midstream();
    int b_rise = rise_cnt;
    bit to;
    fir_ack = 1'b0;
    resend = 1'b1;
    @(posedge clk); #1;
    resend = 1'b0;
    to = 1'b1;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk); #1;
      if (out_ing_valid && out_cnt == 6'd20) begin to = 1'b0; break; end
    end
    cmp++; if (to) begin mis++; $display("FAIL rst_reach20: out_cnt 20 not reached"); end
    rstn = 1'b0;
    #1;
    cmp++; if (out_ing_valid !== 1'b0) begin mis++; $display("FAIL rst_valid: got %b required 0", out_ing_valid); end
    cmp++; if (out_cnt !== 6'd0) begin mis++; $display("FAIL rst_cnt: got %0d required 0", out_cnt); end
    cmp++; if (fir_data !== 16'sd0) begin mis++; $display("FAIL rst_data: got %0d required 0", fir_data); end
    cmp++; if (coef_ready !== 1'b0) begin mis++; $display("FAIL rst_ready: got %b required 0", coef_ready); end
    cmp++; if (busy !== 1'b0) begin mis++; $display("FAIL rst_busy: got %b required 0", busy); end
    repeat (2) @(posedge clk);
    #1;
    rstn = 1'b1;
    @(posedge clk); #1;
    resend = 1'b1;
    @(posedge clk); #1;
    resend = 1'b0;
    repeat (30) @(negedge clk);
    cmp++; if (rise_cnt - b_rise !== 1) begin mis++; $display("FAIL rst_resend: streams %0d required 1", rise_cnt - b_rise); end
    cmp++; if (busy !== 1'b0) begin mis++; $display("FAIL rst_resend_busy: got %b required 0", busy); end
  endtask

  initial begin
    test_reset();
    test_valid_frame();
    test_bad_checksum();
    test_gap_timeout();
    test_ack_timeout_resend();
    test_send_ignore();
    test_reset_midstream();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, mis);
    $finish;
  end

endmodule

// File: doc/fir_coef_sender.md
Name: fir_coef_sender

Overview:
- Loads a 50-entry FIR tap-coefficient set from a UART byte stream and streams it to the FIR filter's coefficient load port.
- Coefficient port signals: out_ing_valid, out_cnt, fir_data, with fir_data_rec_valid as the acknowledge.
- This block is the transmitting end of that port.
- Sits between the UART receiver and the FIR filter, 50 MHz domain.

Parameters:
- NUM_COEF, 50, coefficients per frame. These are half-taps of the symmetric 100-tap filter.
- COEF_HOLD, 2, clocks each out_cnt/fir_data pair is held stable.
- GAP_TIMEOUT, 500000, maximum idle clocks between bytes inside a frame (10 ms at 50 MHz).
- ACK_TIMEOUT, 1024, maximum clocks to wait for fir_data_rec_valid after the last index.
- HEADER, 8'hA5, frame start byte.

Ports:
- clk, input, 1, system clock, 50 MHz.
- rstn, input, 1, asynchronous active-low reset.
- rx_data, input, 8, received UART byte.
- rx_valid, input, 1, one-clock strobe qualifying rx_data.
- resend, input, 1, pulse: re-stream the stored set when coef_ready=1.
- fir_data_rec_valid, input, 1, acknowledge from the filter. Sticky-high once the filter has seen index NUM_COEF-1.
- out_ing_valid, output, 1, high for the whole duration of streaming.
- out_cnt, output, 6, current coefficient index.
- fir_data, output, 16 signed, coefficient at index out_cnt.
- busy, output, 1, high in any state other than IDLE.
- coef_ready, output, 1, a valid coefficient set is stored.
- load_ok, output, 1, one-clock pulse when streaming is acknowledged.
- load_err, output, 1, one-clock pulse on any error: checksum, gap timeout or ack timeout.

Behaviour:
- Reset: asynchronous, rstn active-low, clock clk. All outputs are 0, state is IDLE, and coefficient storage is cleared to 0.
- Frame format: HEADER, then 2*NUM_COEF data bytes, high byte first per coefficient (index 0 first), then one checksum byte.
  - The checksum equals the XOR of all data bytes; the header is excluded.
- IDLE:
  - rx_valid with rx_data==HEADER goes to RECV, clears coef_ready, and clears the byte counter and the running XOR.
  - Any other byte is ignored.
  - resend with coef_ready=1 goes to SEND; otherwise resend is ignored.
- RECV:
  - Each rx_valid stores its byte. Even byte count goes to the high half, odd goes to the low half of coefficient[count>>1]. The byte is XORed into the running checksum.
  - After byte 2*NUM_COEF-1 go to CHECK.
  - Gap counter: reset on every rx_valid. Reaching GAP_TIMEOUT raises load_err, returns to IDLE, and leaves coef_ready=0.
  - A byte equal to HEADER inside the frame is treated as data; there is no resync.
- CHECK:
  - The next rx_valid is the checksum byte; the gap timeout also applies here.
  - Match: set coef_ready and go to SEND.
  - Mismatch: raise load_err, go to IDLE, coef_ready=0.
- SEND:
  - out_ing_valid goes high on the first SEND clock.
  - out_cnt steps 0..NUM_COEF-1. Each value is held for exactly COEF_HOLD clocks, with fir_data registered and consistent with out_cnt on every one of those clocks.
  - Index NUM_COEF-1 is also held for COEF_HOLD clocks with out_ing_valid still high. Then out_ing_valid=0, out_cnt=0, fir_data=0, and the block goes to WAIT_ACK.
  - Streaming duration is exactly NUM_COEF*COEF_HOLD clocks.
- WAIT_ACK:
  - fir_data_rec_valid=1 raises a load_ok pulse and goes to IDLE.
  - ACK_TIMEOUT clocks without the acknowledge raise load_err and go to IDLE. coef_ready stays 1, so resend is allowed.
  - A sticky-high acknowledge from a previous load completes on the first WAIT_ACK clock.
- Ignored inputs:
  - rx_valid in SEND and WAIT_ACK is dropped.
  - resend is ignored outside IDLE.
- Simultaneous events: in IDLE, resend and a HEADER byte in the same clock resolve to the HEADER byte.
- Reset mid-operation: any state returns to IDLE, outputs go to 0 and storage is cleared.
- Widths:
  - Byte counter 7 bits.
  - Hold counter ceil(log2(COEF_HOLD+1)) bits.
  - Timeout counters sized from their parameters.
  - out_cnt never exceeds NUM_COEF-1.

Decomposition:
- Shared package fir_coef_pkg holds:
  - the state enum IDLE/RECV/CHECK/SEND/WAIT_ACK;
  - the NUM_COEF and HEADER defaults;
  - the coefficient type, signed 16-bit.
- One sub-module: fir_coef_frame_rx. It handles byte assembly, checksum and the gap timer, and outputs a coefficient write port plus frame_ok/frame_err pulses.
- The top level holds the coefficient storage, the SEND/WAIT_ACK sequencing and resend.

Test Plan:
- Valid frame, coef[i]=16'sd100*i-2500, correct checksum, ack tied high after the last index.
  - out_cnt 0..49, each held 2 clocks; fir_data[k]=100k-2500.
  - out_ing_valid high for exactly 100 clocks.
  - load_ok pulses once; coef_ready=1.
- Same frame with the checksum XOR 8'h01 -> load_err pulse, no SEND (out_ing_valid stays 0), coef_ready=0.
- Stop after 37 bytes and wait GAP_TIMEOUT+1 clocks -> load_err at clock GAP_TIMEOUT and return to IDLE. A following complete frame loads correctly.
- fir_data_rec_valid held 0 -> load_err ACK_TIMEOUT clocks after out_ing_valid falls, coef_ready=1. Then pulse resend with the ack high -> identical 100-clock stream and load_ok.
- Bytes sent during SEND, including 8'hA5 -> ignored; the stream is unchanged and busy stays 1.
- rstn asserted at out_cnt=20 -> out_ing_valid, out_cnt and fir_data are 0 immediately; coef_ready=0; resend is ignored after release.
